// File: rtl/ring_buffer_pkg.sv
// Shared defaults and helper types for the ring_buffer FIFO and its storage array.
package ring_buffer_pkg;

    localparam int RB_DATA_WIDTH = 8;
    localparam int RB_DEPTH      = 4;
    localparam int RB_ADDR_WIDTH = $clog2(RB_DEPTH);

    // The two accepted-operation bits, {do_wr, do_rd}, viewed as one operation code.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } rb_op_e;

    function automatic logic is_pow2_depth(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/ring_buffer_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write port and a registered read port
// whose output register clears on reset while the storage itself does not.
module ring_buffer_mem
    import ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int DEPTH      = RB_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // NOTE: the storage array has no reset; stale entries are unreachable once the
    // pointers and count are cleared, and leaving it unreset lets it map to plain flops/RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ring_buffer.sv
// Single-clock circular FIFO: pointer, occupancy and registered full/empty flag logic
// around a ring_buffer_mem storage array.
module ring_buffer
    import ring_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = RB_DATA_WIDTH,
    parameter int DEPTH      = RB_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    input  logic                  read_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0]   LP_COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LP_COUNT_STEP = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] LP_PTR_STEP   = ADDR_WIDTH'(1);

    if (!is_pow2_depth(DEPTH) || (ADDR_WIDTH != $clog2(DEPTH))) begin : g_bad_params
        $error("ring_buffer: DEPTH must be a power of two >= 2 and ADDR_WIDTH = log2(DEPTH)");
    end

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  r_full;
    logic                  r_empty;
    logic                  w_do_wr;
    logic                  w_do_rd;
    rb_op_e                w_op;

    // Acceptance uses the registered flags, so a push into a full buffer or a pop from
    // an empty one is dropped, and a simultaneous push+pop at either extreme does one side only.
    assign w_do_wr = write_en & ~r_full;
    assign w_do_rd = read_en & ~r_empty;
    assign w_op    = rb_op_e'({w_do_wr, w_do_rd});

    // NOTE: always_comb outputs get a default before the case so every path assigns
    // them and no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        case (w_op)
            OP_PUSH: w_count_next = r_count + LP_COUNT_STEP;
            OP_POP:  w_count_next = r_count - LP_COUNT_STEP;
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR_STEP;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + LP_PTR_STEP;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == LP_COUNT_FULL);
            r_empty <= (w_count_next == '0);
        end
    end

    // Reset takes priority over a push on the same edge, so the array is not written then.
    ring_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_do_wr & ~rst),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (write_data),
        .i_rd_en    (w_do_rd),
        .i_rd_addr  (r_rd_ptr),
        .o_rd_data  (read_data)
    );

    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: tb/tb_ring_buffer.sv
// Scoreboard bench for ring_buffer: directed steps queue hand-computed expectations,
// a monitor process compares them against the outputs after each clock edge.
module tb_ring_buffer;

    logic       clk;
    logic       rst;
    logic       write_en;
    logic       read_en;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       full;
    logic       empty;

    typedef struct {
        int         id;
        logic [7:0] rd;
        logic       full;
        logic       empty;
        logic [2:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    ring_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .read_en    (read_en),
        .write_data (write_data),
        .read_data  (read_data),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input int id, input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0d expected %0d", id, nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue what the next rising
    // edge must produce.
    task automatic step(input logic r, input logic we, input logic re, input logic [7:0] wd,
                        input logic [7:0] e_rd, input logic e_full, input logic e_empty,
                        input logic [2:0] e_cnt);
        exp_t e;
        @(negedge clk);
        rst        = r;
        write_en   = we;
        read_en    = re;
        write_data = wd;
        e.id    = step_id;
        e.rd    = e_rd;
        e.full  = e_full;
        e.empty = e_empty;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
        step_id++;
    endtask

    // Monitor: each rising edge completes exactly one queued step.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check(e.id, "read_data", {24'd0, read_data}, {24'd0, e.rd});
                check(e.id, "full", {31'd0, full}, {31'd0, e.full});
                check(e.id, "empty", {31'd0, empty}, {31'd0, e.empty});
                check(e.id, "count", {29'd0, dut.r_count}, {29'd0, e.cnt});
            end
        end
    end

    initial begin
        rst        = 1'b1;
        write_en   = 1'b0;
        read_en    = 1'b0;
        write_data = 8'd0;

        //   rst we re wd     rd   full empty cnt
        step(1, 0, 0, 8'd0,   8'd0,   0, 1, 3'd0);   // reset state
        // fill: empty drops on first push, full rises on fourth
        step(0, 1, 0, 8'd10,  8'd0,   0, 0, 3'd1);
        step(0, 1, 0, 8'd20,  8'd0,   0, 0, 3'd2);
        step(0, 1, 0, 8'd30,  8'd0,   0, 0, 3'd3);
        step(0, 1, 0, 8'd40,  8'd0,   1, 0, 3'd4);
        // push while full is dropped, then drain in order
        step(0, 1, 0, 8'd50,  8'd0,   1, 0, 3'd4);
        step(0, 0, 1, 8'd0,   8'd10,  0, 0, 3'd3);
        step(0, 0, 1, 8'd0,   8'd20,  0, 0, 3'd2);
        step(0, 0, 1, 8'd0,   8'd30,  0, 0, 3'd1);
        step(0, 0, 1, 8'd0,   8'd40,  0, 1, 3'd0);
        // pop while empty holds read_data
        step(0, 0, 1, 8'd0,   8'd40,  0, 1, 3'd0);
        step(0, 0, 1, 8'd0,   8'd40,  0, 1, 3'd0);
        // advance both pointers to index 2
        step(0, 1, 0, 8'd1,   8'd40,  0, 0, 3'd1);
        step(0, 0, 1, 8'd0,   8'd1,   0, 1, 3'd0);
        step(0, 1, 0, 8'd2,   8'd1,   0, 0, 3'd1);
        step(0, 0, 1, 8'd0,   8'd2,   0, 1, 3'd0);
        // wrap-around past index 3
        step(0, 1, 0, 8'd100, 8'd2,   0, 0, 3'd1);
        step(0, 1, 0, 8'd200, 8'd2,   0, 0, 3'd2);
        step(0, 0, 1, 8'd0,   8'd100, 0, 0, 3'd1);
        step(0, 1, 0, 8'd150, 8'd100, 0, 0, 3'd2);
        step(0, 0, 1, 8'd0,   8'd200, 0, 0, 3'd1);
        step(0, 0, 1, 8'd0,   8'd150, 0, 1, 3'd0);
        // simultaneous push+pop when empty: push only
        step(0, 1, 1, 8'd7,   8'd150, 0, 0, 3'd1);
        step(0, 1, 0, 8'd8,   8'd150, 0, 0, 3'd2);
        // simultaneous at count 2: both happen, order preserved
        step(0, 1, 1, 8'd9,   8'd7,   0, 0, 3'd2);
        step(0, 1, 1, 8'd10,  8'd8,   0, 0, 3'd2);
        step(0, 1, 0, 8'd11,  8'd8,   0, 0, 3'd3);
        step(0, 1, 0, 8'd12,  8'd8,   1, 0, 3'd4);
        // simultaneous when full: pop only, 99 is dropped
        step(0, 1, 1, 8'd99,  8'd9,   0, 0, 3'd3);
        step(0, 0, 1, 8'd0,   8'd10,  0, 0, 3'd2);
        step(0, 0, 1, 8'd0,   8'd11,  0, 0, 3'd1);
        step(0, 0, 1, 8'd0,   8'd12,  0, 1, 3'd0);
        step(0, 0, 1, 8'd0,   8'd12,  0, 1, 3'd0);
        // reset mid-stream at count 3, reset wins over a push
        step(0, 1, 0, 8'd21,  8'd12,  0, 0, 3'd1);
        step(0, 1, 0, 8'd22,  8'd12,  0, 0, 3'd2);
        step(0, 1, 0, 8'd23,  8'd12,  0, 0, 3'd3);
        step(1, 1, 0, 8'd77,  8'd0,   0, 1, 3'd0);
        step(0, 1, 0, 8'd55,  8'd0,   0, 0, 3'd1);
        step(0, 0, 1, 8'd0,   8'd55,  0, 1, 3'd0);
        step(0, 0, 0, 8'd0,   8'd55,  0, 1, 3'd0);

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        check(-1, "scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
